// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector serializer.
package vec_pkg;

  // IDLE: no word held. SHIFT: a word is held and its bits are being offered.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } vser_state_t;

  // Bit-counter width for a w-bit word: enough to index beats 0..w-1, never 0.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/vec_serializer.sv
// Parallel-in / serial-out vector block.
// A word is captured on the in_valid/in_ready handshake and held on outv.
// The same bits are streamed one per beat on ser_valid/ser_ready, MSB-first
// or LSB-first. A new word may be taken on the final beat of the current one,
// which gives gap-free back-to-back streaming.
module vec_serializer
  import vec_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] outv,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             busy
);

  localparam int              CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  vser_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] outv_q, outv_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_last_q, ser_last_d;

  logic             accept;
  logic             beat;
  logic             final_beat;
  logic [CW-1:0]    cnt_inc;

  // Bit offered on beat k of a word, honouring the configured bit order.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [CW-1:0]    k);
    logic [WIDTH-1:0] sh;
    if (LSB_FIRST != 0) begin
      sh = word >> k;
      return sh[0];
    end else begin
      sh = word << k;
      return sh[WIDTH-1];
    end
  endfunction

  // Ready to take a word when empty, or when the last bit leaves this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (resetn) begin
      if (state_q == IDLE) begin
        in_ready = 1'b1;
      end else begin
        in_ready = ser_valid_q & ser_ready & ser_last_q;
      end
    end
  end

  assign accept     = in_valid & in_ready;
  assign beat       = ser_valid_q & ser_ready;
  assign final_beat = beat & ser_last_q;
  assign cnt_inc    = cnt_q + CW'(1);

  // Next-state: load on accept, advance on a non-final beat, drain on final.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    outv_d      = outv_q;
    ser_valid_d = ser_valid_q;
    ser_bit_d   = ser_bit_q;
    ser_last_d  = ser_last_q;

    if (accept) begin
      // covers both the IDLE load and the no-bubble reload on a final beat
      state_d     = SHIFT;
      cnt_d       = '0;
      outv_d      = vec;
      ser_valid_d = 1'b1;
      ser_bit_d   = pick_bit(vec, '0);
      ser_last_d  = (LAST_CNT == '0);
    end else if (final_beat) begin
      state_d     = IDLE;
      cnt_d       = '0;
      ser_valid_d = 1'b0;
      ser_bit_d   = 1'b0;
      ser_last_d  = 1'b0;
    end else if (beat) begin
      // a non-final beat implies cnt_q < LAST_CNT, so the increment never wraps
      cnt_d       = cnt_inc;
      ser_bit_d   = pick_bit(outv_q, cnt_inc);
      ser_last_d  = (cnt_inc == LAST_CNT);
    end
  end

  // State, counter, held word and serial outputs; reset discards any partial word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      outv_q      <= '0;
      ser_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      outv_q      <= outv_d;
      ser_valid_q <= ser_valid_d;
      ser_bit_q   <= ser_bit_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign outv      = outv_q;
  assign ser_valid = ser_valid_q;
  assign ser_bit   = ser_bit_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_vec_serializer.sv
// Bench for vec_serializer: an MSB-first and an LSB-first WIDTH=3 instance
// driven with identical stimulus, plus a WIDTH=1 instance.
module tb_vec_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       iv;
  logic [2:0] vin;
  logic       rdy;

  logic       m_ir, m_sv, m_sb, m_sl, m_busy;
  logic [2:0] m_ov;
  logic       l_ir, l_sv, l_sb, l_sl, l_busy;
  logic [2:0] l_ov;

  logic       w_iv, w_rdy;
  logic [0:0] w_vin, w_ov;
  logic       w_ir, w_sv, w_sb, w_sl, w_busy;

  int checks   = 0;
  int failures = 0;

  vec_serializer #(.WIDTH(3), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .resetn(resetn), .in_valid(iv), .in_ready(m_ir), .vec(vin),
    .outv(m_ov), .ser_valid(m_sv), .ser_ready(rdy), .ser_bit(m_sb),
    .ser_last(m_sl), .busy(m_busy));

  vec_serializer #(.WIDTH(3), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .resetn(resetn), .in_valid(iv), .in_ready(l_ir), .vec(vin),
    .outv(l_ov), .ser_valid(l_sv), .ser_ready(rdy), .ser_bit(l_sb),
    .ser_last(l_sl), .busy(l_busy));

  vec_serializer #(.WIDTH(1), .LSB_FIRST(0)) dut_w1 (
    .clk(clk), .resetn(resetn), .in_valid(w_iv), .in_ready(w_ir), .vec(w_vin),
    .outv(w_ov), .ser_valid(w_sv), .ser_ready(w_rdy), .ser_bit(w_sb),
    .ser_last(w_sl), .busy(w_busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic vld, input logic bm, input logic bl,
                          input logic last, input logic [2:0] ov, input logic bsy,
                          input logic rdy_e);
    chk({tag, " m.ser_valid"}, m_sv, vld);
    chk({tag, " m.ser_bit"},   m_sb, bm);
    chk({tag, " m.ser_last"},  m_sl, last);
    chk({tag, " m.outv"},      m_ov, ov);
    chk({tag, " m.busy"},      m_busy, bsy);
    chk({tag, " m.in_ready"},  m_ir, rdy_e);
    chk({tag, " l.ser_valid"}, l_sv, vld);
    chk({tag, " l.ser_bit"},   l_sb, bl);
    chk({tag, " l.ser_last"},  l_sl, last);
    chk({tag, " l.outv"},      l_ov, ov);
    chk({tag, " l.busy"},      l_busy, bsy);
    chk({tag, " l.in_ready"},  l_ir, rdy_e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word from IDLE with the sink always ready; em/el list beats 0..2 as bits [2..0].
  task automatic send_word(input string tag, input logic [2:0] v,
                           input logic [2:0] em, input logic [2:0] el);
    iv = 1'b1; vin = v; rdy = 1'b1;
    @(negedge clk);
    chk({tag, " idle m.in_ready"}, m_ir, 1'b1);
    chk({tag, " idle l.in_ready"}, l_ir, 1'b1);
    tick();
    iv = 1'b0; vin = 3'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_both($sformatf("%s beat%0d", tag, k), 1'b1, em[2-k], el[2-k], k == 2, v, 1'b1, k == 2);
      tick();
    end
    @(negedge clk);
    chk_both({tag, " drained"}, 1'b0, 1'b0, 1'b0, 1'b0, v, 1'b0, 1'b1);
    tick();
  endtask

  typedef struct {
    logic [2:0] v;
    logic [2:0] exp_m;
    logic [2:0] exp_l;
  } dvec_t;

  dvec_t tbl[6];

  logic [1:0] qm[$];
  logic [1:0] ql[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] b2b_m;
    logic [5:0] b2b_l;
    logic [1:0] e;
    logic [2:0] exp_ov_m, exp_ov_l;
    int idx, cyc, beats_m, beats_l;

    tbl[0] = '{v: 3'b101, exp_m: 3'b101, exp_l: 3'b101};
    tbl[1] = '{v: 3'b110, exp_m: 3'b110, exp_l: 3'b011};
    tbl[2] = '{v: 3'b011, exp_m: 3'b011, exp_l: 3'b110};
    tbl[3] = '{v: 3'b100, exp_m: 3'b100, exp_l: 3'b001};
    tbl[4] = '{v: 3'b000, exp_m: 3'b000, exp_l: 3'b000};
    tbl[5] = '{v: 3'b111, exp_m: 3'b111, exp_l: 3'b111};

    resetn = 1'b0; iv = 1'b1; vin = 3'b111; rdy = 1'b1;
    w_iv = 1'b0; w_vin = 1'b0; w_rdy = 1'b0;

    // reset values, with in_valid asserted to show in_ready stays low
    @(negedge clk);
    chk_both("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("reset w1.ser_valid", w_sv, 1'b0);
    chk("reset w1.in_ready", w_ir, 1'b0);
    chk("reset w1.outv", w_ov, 1'b0);
    @(posedge clk); #1;
    iv = 1'b0; resetn = 1'b1;
    @(negedge clk);
    chk_both("after reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    tick();

    // directed words from the table
    for (int i = 0; i < 6; i++)
      send_word($sformatf("tbl%0d", i), tbl[i].v, tbl[i].exp_m, tbl[i].exp_l);

    // backpressure on the second beat of 3'b011
    iv = 1'b1; vin = 3'b011; rdy = 1'b1;
    @(negedge clk);
    tick();
    iv = 1'b0;
    @(negedge clk); chk_both("bp beat0", 1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0); tick();
    rdy = 1'b0;
    @(negedge clk); chk_both("bp stall0", 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0); tick();
    @(negedge clk); chk_both("bp stall1", 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0); tick();
    rdy = 1'b1;
    @(negedge clk); chk_both("bp beat1", 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0); tick();
    @(negedge clk); chk_both("bp beat2", 1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1); tick();
    @(negedge clk); chk_both("bp drained", 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1); tick();

    // back-to-back 3'b011 then 3'b100 with in_valid held
    b2b_m = 6'b011100;
    b2b_l = 6'b110001;
    iv = 1'b1; vin = 3'b011; rdy = 1'b1;
    @(negedge clk);
    chk("b2b first in_ready", m_ir, 1'b1);
    tick();
    vin = 3'b100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_both($sformatf("b2b beat%0d", k), 1'b1, b2b_m[5-k], b2b_l[5-k],
               (k == 2) || (k == 5), (k < 3) ? 3'b011 : 3'b100, 1'b1, (k == 2) || (k == 5));
      tick();
      if (k == 2) iv = 1'b0;
    end
    @(negedge clk);
    chk_both("b2b drained", 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1);
    tick();

    // reset mid-word: 3'b111, reset asserted between clock edges after beat 0
    iv = 1'b1; vin = 3'b111; rdy = 1'b1;
    @(negedge clk);
    tick();
    iv = 1'b0;
    @(negedge clk); chk_both("rst-mid beat0", 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0);
    tick();
    #2 resetn = 1'b0;
    #1;
    chk_both("rst-mid async", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk_both("rst-mid released", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    tick();
    send_word("post-reset", 3'b010, 3'b010, 3'b010);

    // random sweep of words 0..7 against a bit-queue scoreboard
    exp_ov_m = 3'b010; exp_ov_l = 3'b010;
    idx = 0; cyc = 0; beats_m = 0; beats_l = 0;
    while ((idx < 8 || qm.size() != 0 || ql.size() != 0) && cyc < 400) begin
      iv  = (idx < 8) ? ($urandom_range(0, 3) != 0) : 1'b0;
      vin = iv ? 3'(idx) : 3'($urandom);
      rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("sweep m.ser_valid", m_sv, qm.size() != 0);
      chk("sweep l.ser_valid", l_sv, ql.size() != 0);
      chk("sweep m.in_ready", m_ir, (qm.size() == 0) || (qm.size() == 1 && rdy));
      chk("sweep l.in_ready", l_ir, (ql.size() == 0) || (ql.size() == 1 && rdy));
      chk("sweep m.outv", m_ov, exp_ov_m);
      chk("sweep l.outv", l_ov, exp_ov_l);
      if (m_sv && rdy && qm.size() != 0) begin
        e = qm.pop_front();
        chk("sweep m.ser_bit", m_sb, e[1]);
        chk("sweep m.ser_last", m_sl, e[0]);
        beats_m++;
      end
      if (l_sv && rdy && ql.size() != 0) begin
        e = ql.pop_front();
        chk("sweep l.ser_bit", l_sb, e[1]);
        chk("sweep l.ser_last", l_sl, e[0]);
        beats_l++;
      end
      if (iv && m_ir) begin
        for (int k = 0; k < 3; k++) qm.push_back({vin[2-k], 1'(k == 2)});
        exp_ov_m = vin;
        idx++;
      end
      if (iv && l_ir) begin
        for (int k = 0; k < 3; k++) ql.push_back({vin[k], 1'(k == 2)});
        exp_ov_l = vin;
      end
      tick();
      cyc++;
    end
    chk("sweep finished in budget", cyc < 400, 1'b1);
    chk("sweep m beats", beats_m, 24);
    chk("sweep l beats", beats_l, 24);
    iv = 1'b0; rdy = 1'b0;

    // WIDTH=1: every beat is final; back-to-back then a stalled beat
    w_iv = 1'b1; w_vin = 1'b1; w_rdy = 1'b1;
    @(negedge clk);
    chk("w1 idle in_ready", w_ir, 1'b1);
    tick();
    w_vin = 1'b0;
    @(negedge clk);
    chk("w1 b0 ser_valid", w_sv, 1'b1);
    chk("w1 b0 ser_bit", w_sb, 1'b1);
    chk("w1 b0 ser_last", w_sl, 1'b1);
    chk("w1 b0 outv", w_ov, 1'b1);
    chk("w1 b0 in_ready", w_ir, 1'b1);
    tick();
    w_iv = 1'b0; w_rdy = 1'b0;
    @(negedge clk);
    chk("w1 b1 ser_valid", w_sv, 1'b1);
    chk("w1 b1 ser_bit", w_sb, 1'b0);
    chk("w1 b1 ser_last", w_sl, 1'b1);
    chk("w1 b1 outv", w_ov, 1'b0);
    chk("w1 stall in_ready", w_ir, 1'b0);
    tick();
    w_rdy = 1'b1;
    @(negedge clk);
    chk("w1 held ser_valid", w_sv, 1'b1);
    chk("w1 held ser_last", w_sl, 1'b1);
    chk("w1 held in_ready", w_ir, 1'b1);
    tick();
    @(negedge clk);
    chk("w1 drained ser_valid", w_sv, 1'b0);
    chk("w1 drained busy", w_busy, 1'b0);
    chk("w1 drained outv", w_ov, 1'b0);
    chk("w1 drained in_ready", w_ir, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_serializer.md
Name: vec_serializer

Overview:
- Parametrised successor of the vector-split block.
- Captures a WIDTH-bit vector on a valid/ready handshake and holds a registered copy on outv (the parallel "split" view).
- Streams the same bits one per cycle on a serial valid/ready channel, MSB-first or LSB-first.
- Sits between a parallel word source and a 1-bit consumer (bit-bang or scan-style sink).

Parameters:
- WIDTH, 3, vector width; legal range 1..64.
- LSB_FIRST, 0, 0 = MSB sent first, 1 = LSB sent first.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  source presents vec.
- in_ready  output  1  block can accept vec this cycle.
- vec  input  WIDTH  parallel vector in.
- outv  output  WIDTH  registered copy of the last accepted vec.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  sink takes ser_bit this cycle.
- ser_bit  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the word.
- busy  output  1  state is SHIFT.

Behaviour:
- Reset (async assert, sync release): state = IDLE, outv = 0, ser_valid = 0, ser_bit = 0, ser_last = 0, bit counter = 0, busy = 0.
- During reset, in_ready = 0.
- States:
  - IDLE: no word held.
  - SHIFT: word held, ser_valid = 1.
- in_ready is combinational:
  - 1 in IDLE.
  - In SHIFT, equals ser_valid & ser_ready & ser_last (the final-beat handshake).
  - 0 otherwise.
- Accept = in_valid & in_ready. vec is ignored when there is no accept.
- On accept (latency 1):
  - Next cycle outv = vec and state = SHIFT.
  - ser_valid = 1, counter = 0.
  - ser_bit = vec[WIDTH-1] (MSB-first) or vec[0] (LSB-first).
- In SHIFT, beat k (k = 0..WIDTH-1):
  - ser_bit = outv[WIDTH-1-k] for MSB-first, outv[k] for LSB-first.
  - ser_last = (k == WIDTH-1).
- Beat handshake = ser_valid & ser_ready.
  - On a non-final beat, the counter increments.
  - On the final beat, with an accept in the same cycle: reload the new word and stay in SHIFT with no bubble.
  - On the final beat, with no accept: go to IDLE; ser_valid, ser_last and ser_bit drop to 0 next cycle.
- Backpressure: while ser_valid & !ser_ready, ser_bit, ser_last, counter and outv hold.
- outv changes only on accept and holds after the word drains.
- WIDTH = 1: ser_last = 1 on the only beat; every beat is a final beat.
- Counter width: max(1, $clog2(WIDTH)). It never exceeds WIDTH-1, with no wrap beyond it.
- Reset mid-word: the partial word is discarded immediately and all outputs take reset values. After release, the block is in IDLE with in_ready = 1.
- No X propagation: once out of reset, all outputs are driven to 0/1 every cycle.

Decomposition:
- Shared package vec_pkg holds:
  - typedef enum logic {IDLE, SHIFT} vser_state_t;
  - function cnt_w(int w) returning max(1, $clog2(w)).
- No sub-module. One sequential process (state, counter, outv) plus combinational bit select and ready.

Test Plan:
- WIDTH=3, LSB_FIRST=0, vec=3'b101 accepted, ser_ready=1 -> ser_bit 1,0,1 on the next 3 cycles; ser_last only on the 3rd; outv=3'b101 from cycle 1 onward; busy drops after the 3rd beat.
- LSB_FIRST=1, vec=3'b110 -> ser_bit 0,1,1; ser_last on the 3rd beat; in_ready=0 during beats 1-2.
- Backpressure: vec=3'b011, ser_ready low for 2 cycles at beat 2 -> ser_bit=1 and ser_last=0 held; word completes in 5 cycles; outv stays 3'b011.
- Back-to-back: in_valid held with 3'b011 then 3'b100, ser_ready=1 -> 6 contiguous beats 0,1,1,1,0,0; in_ready=1 only on beat 3; outv changes to 3'b100 after beat 3.
- Reset mid-word: resetn low after beat 1 of 3'b111 -> ser_valid, outv and busy go to 0 without waiting for clk; after release in_ready=1 and the next word 3'b010 streams 0,1,0.
- Sweep: accept vec = 0..7 with ser_ready random at 50% -> outv equals each accepted vec; the concatenated serial stream matches all vecs in order with no lost or duplicated beats.
